lsu: RTL and testbench

- Load/store unit between the MEM pipeline stage and the byte-addressed data memory.
- Accepts one load or store request per handshake and decodes RISC-V funct3 into the data memory's size code.
- Detects misaligned and illegal accesses and drives the memory port for exactly one cycle.
- Returns a registered response (load data or exception) to writeback over a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_decode.sv | 66 ++++++
 rtl/lsu.sv | 149 ++++++++++++++
 tb/tb_lsu.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, the data
// memory's size codes, mcause values and RISC-V load/store funct3 encodings.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Data memory size codes; bit 2 asks the memory to sign-extend
  localparam logic [2:0] SZ_B    = 3'b000;
  localparam logic [2:0] SZ_H    = 3'b001;
  localparam logic [2:0] SZ_W    = 3'b010;
  localparam logic [2:0] SZ_BS   = 3'b100;
  localparam logic [2:0] SZ_HS   = 3'b101;
  localparam logic [2:0] SZ_NONE = 3'b011;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Offset of the last byte touched by an access of the given width
  function automatic logic [1:0] accessSpan(input logic [1:0] width);
    logic [1:0] span;
    span = 2'd0;
    case (width)
      2'b01:   span = 2'd1;
      2'b10:   span = 2'd3;
      default: span = 2'd0;
    endcase
    return span;
  endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational request decode: funct3/we/addr to memory size code plus the
// exception flag and mcause. Defining LSU_BOUNDS_CHECK_EN adds an access-fault
// check against MEM_BYTES (lowest priority after illegal and misaligned).
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 32
) (
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [2:0]        o_size,
  output logic              o_exc,
  output logic [3:0]        o_cause
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  logic            w_illegal;
  logic            w_misaligned;
  logic            w_outOfRange;
  logic [ADDR_W:0] w_lastByte;

  // Classify the access, pick the size code and resolve exception priority
  always_comb begin
    w_illegal    = i_we ? (i_funct3 >= 3'b011)
                        : (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11);
    w_misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b01:   w_misaligned = i_addr[0];
      2'b10:   w_misaligned = |i_addr[1:0];
      default: w_misaligned = 1'b0;
    endcase
    w_lastByte   = {1'b0, i_addr} + (ADDR_W+1)'(accessSpan(i_funct3[1:0]));
    w_outOfRange = BOUNDS_EN && (w_lastByte >= (ADDR_W+1)'(MEM_BYTES));

    o_size = SZ_NONE;
    case ({i_we, i_funct3})
      {1'b0, F3_B}:  o_size = SZ_BS;
      {1'b0, F3_H}:  o_size = SZ_HS;
      {1'b0, F3_W}:  o_size = SZ_W;
      {1'b0, F3_BU}: o_size = SZ_B;
      {1'b0, F3_HU}: o_size = SZ_H;
      {1'b1, F3_B}:  o_size = SZ_B;
      {1'b1, F3_H}:  o_size = SZ_H;
      {1'b1, F3_W}:  o_size = SZ_W;
      default:       o_size = SZ_NONE;
    endcase

    o_exc   = w_illegal | w_misaligned | w_outOfRange;
    o_cause = 4'd0;
    if (w_illegal) begin
      o_cause = CAUSE_ILLEGAL;
    end else if (w_misaligned) begin
      o_cause = i_we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    end else if (w_outOfRange) begin
      o_cause = i_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between MEM and the byte-addressed data memory. One request
// per handshake: accept (IDLE), one-cycle memory access (ACC), registered
// response held until consumed (RESP). Optional bounds check: LSU_BOUNDS_CHECK_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWe,
  input  logic [2:0]        reqFunct3,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [31:0]       reqWData,
  input  logic [4:0]        reqRd,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [31:0]       rspData,
  output logic [4:0]        rspRd,
  output logic              rspRdWe,
  output logic              rspExc,
  output logic [3:0]        rspCause,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWData,
  output logic [2:0]        memSize,
  output logic              memWEn,
  input  logic [31:0]       memRData,
  output logic              busy
);

  lsu_state_t        r_state;
  lsu_state_t        w_nextState;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [4:0]        r_rd;
  logic [2:0]        r_size;
  logic              r_exc;
  logic [3:0]        r_cause;

  logic [31:0]       r_rspData;
  logic [4:0]        r_rspRd;
  logic              r_rspRdWe;
  logic              r_rspExc;
  logic [3:0]        r_rspCause;

  logic [2:0]        w_size;
  logic              w_exc;
  logic [3:0]        w_cause;

  lsu_decode #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W)
  ) u_decode (
    .i_we    (reqWe),
    .i_funct3(reqFunct3),
    .i_addr  (reqAddr),
    .o_size  (w_size),
    .o_exc   (w_exc),
    .o_cause (w_cause)
  );

  // State register; reset drops any in-flight transaction
  always_ff @(posedge clk) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next state and handshake/memory strobes; the write strobe is gated by
  // reset so an access interrupted by reset never lands in memory
  always_comb begin
    w_nextState = r_state;
    reqReady    = 1'b0;
    rspValid    = 1'b0;
    busy        = 1'b1;
    memSize     = SZ_NONE;
    memWEn      = 1'b0;
    case (r_state)
      IDLE: begin
        reqReady = 1'b1;
        busy     = 1'b0;
        if (reqValid) w_nextState = ACC;
      end
      ACC: begin
        memSize     = r_size;
        memWEn      = r_we & ~r_exc & rstN;
        w_nextState = RESP;
      end
      RESP: begin
        rspValid = 1'b1;
        if (rspReady) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Latch the accepted request together with its decode result
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_size  <= SZ_NONE;
      r_exc   <= 1'b0;
      r_cause <= '0;
    end else if (r_state == IDLE && reqValid) begin
      r_we    <= reqWe;
      r_addr  <= reqAddr;
      r_wdata <= reqWData;
      r_rd    <= reqRd;
      r_size  <= w_size;
      r_exc   <= w_exc;
      r_cause <= w_cause;
    end
  end

  // Build the response during the access cycle; it then holds through RESP
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_rspData  <= '0;
      r_rspRd    <= '0;
      r_rspRdWe  <= 1'b0;
      r_rspExc   <= 1'b0;
      r_rspCause <= '0;
    end else if (r_state == ACC) begin
      r_rspExc   <= r_exc;
      r_rspCause <= r_cause;
      r_rspRdWe  <= ~r_we & ~r_exc;
      r_rspRd    <= r_we ? 5'd0 : r_rd;
      if (r_exc)     r_rspData <= 32'(r_addr);
      else if (r_we) r_rspData <= 32'd0;
      else           r_rspData <= memRData;
    end
  end

  assign memAddr  = r_addr;
  assign memWData = r_wdata;
  assign rspData  = r_rspData;
  assign rspRd    = r_rspRd;
  assign rspRdWe  = r_rspRdWe;
  assign rspExc   = r_rspExc;
  assign rspCause = r_rspCause;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed scenarios followed by randomized loads/stores,
// checked against a byte-array reference model of RISC-V load/store semantics.
// Honours LSU_BOUNDS_CHECK_EN when the design is built with it.
module tb_lsu;

  localparam int MEMB = 4096;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic [4:0]  reqRd;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspData;
  logic [4:0]  rspRd;
  logic        rspRdWe;
  logic        rspExc;
  logic [3:0]  rspCause;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [2:0]  memSize;
  logic        memWEn;
  logic [31:0] memRData;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Device memory seen by the DUT and the independent reference copy
  logic [7:0] devMem [0:MEMB-1];
  logic [7:0] refMem [0:MEMB-1];
  logic [7:0] rb0, rb1, rb2, rb3;

  // Expected response of the transaction in flight
  logic        expExc;
  logic [3:0]  expCause;
  logic [31:0] expData;
  logic [4:0]  expRd;
  logic        expRdWe;
  logic        expWEn;
  logic [2:0]  expSize;

  lsu #(
    .MEM_BYTES(MEMB),
    .ADDR_W   (32)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqWe    (reqWe),
    .reqFunct3(reqFunct3),
    .reqAddr  (reqAddr),
    .reqWData (reqWData),
    .reqRd    (reqRd),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspData  (rspData),
    .rspRd    (rspRd),
    .rspRdWe  (rspRdWe),
    .rspExc   (rspExc),
    .rspCause (rspCause),
    .memAddr  (memAddr),
    .memWData (memWData),
    .memSize  (memSize),
    .memWEn   (memWEn),
    .memRData (memRData),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Combinational memory read port that extends according to the size code
  always_comb begin
    rb0 = devMem[memAddr[11:0]];
    rb1 = devMem[memAddr[11:0] + 12'd1];
    rb2 = devMem[memAddr[11:0] + 12'd2];
    rb3 = devMem[memAddr[11:0] + 12'd3];
    memRData = 32'd0;
    case (memSize[1:0])
      2'b00: memRData = memSize[2] ? {{24{rb0[7]}}, rb0} : {24'd0, rb0};
      2'b01: memRData = memSize[2] ? {{16{rb1[7]}}, rb1, rb0} : {16'd0, rb1, rb0};
      2'b10: memRData = {rb3, rb2, rb1, rb0};
      default: memRData = 32'd0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Memory write, applied just before the clock edge that ends the access cycle
  task automatic deviceWrite();
    int nb;
    if (memWEn) begin
      nb = (memSize[1:0] == 2'b00) ? 1 : (memSize[1:0] == 2'b01) ? 2 : 4;
      for (int k = 0; k < nb; k++)
        devMem[12'(memAddr + 32'(k))] = 8'(memWData >> (8 * k));
    end
  endtask

  // Reference behaviour computed from the RISC-V load/store rules
  task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
    bit     illegal, mis, oob;
    int     nb;
    longint v;
    illegal = we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
    nb      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis     = (addr % nb) != 0;
    oob     = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
    oob     = (longint'(addr) + nb - 1) >= MEMB;
`endif
    expExc   = illegal || mis || oob;
    expCause = illegal ? 4'd2 : mis ? (we ? 4'd6 : 4'd4) : oob ? (we ? 4'd7 : 4'd5) : 4'd0;
    expWEn   = we && !expExc;
    if (we) expSize = (f3 == 3'd0) ? 3'b000 : (f3 == 3'd1) ? 3'b001 : 3'b010;
    else    expSize = (f3 == 3'd0) ? 3'b100 : (f3 == 3'd1) ? 3'b101 :
                      (f3 == 3'd2) ? 3'b010 : (f3 == 3'd4) ? 3'b000 : 3'b001;
    if (expExc) begin
      expData = addr;
      expRd   = we ? 5'd0 : rd;
      expRdWe = 1'b0;
    end else if (we) begin
      for (int k = 0; k < nb; k++)
        refMem[12'(addr + 32'(k))] = 8'(wdata >> (8 * k));
      expData = 32'd0;
      expRd   = 5'd0;
      expRdWe = 1'b0;
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++)
        v += longint'(refMem[12'(addr + 32'(k))]) << (8 * k);
      if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
        v -= longint'(1) << (8 * nb);
      expData = 32'(v);
      expRd   = rd;
      expRdWe = 1'b1;
    end
  endtask

  task automatic checkResponse(input string tag);
    checkOutput({tag, "_rspValid"}, rspValid, 1'b1);
    checkOutput({tag, "_rspExc"}, rspExc, expExc);
    checkOutput({tag, "_rspCause"}, rspCause, expCause);
    checkOutput({tag, "_rspData"}, rspData, expData);
    checkOutput({tag, "_rspRd"}, rspRd, expRd);
    checkOutput({tag, "_rspRdWe"}, rspRdWe, expRdWe);
    checkOutput({tag, "_reqReady"}, reqReady, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b1);
    checkOutput({tag, "_memWEn"}, memWEn, 1'b0);
    checkOutput({tag, "_memSize"}, memSize, 3'b011);
  endtask

  // One full transaction: accept, access cycle, response held for holdCycles
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd, input int holdCycles);
    predict(we, f3, addr, wdata, rd);
    checkOutput("idle_reqReady", reqReady, 1'b1);
    checkOutput("idle_busy", busy, 1'b0);
    reqValid  = 1'b1;
    reqWe     = we;
    reqFunct3 = f3;
    reqAddr   = addr;
    reqWData  = wdata;
    reqRd     = rd;
    @(posedge clk); #1;
    reqValid  = 1'b0;
    reqWe     = 1'($urandom);
    reqFunct3 = 3'($urandom);
    reqAddr   = $urandom;
    reqWData  = $urandom;
    reqRd     = 5'($urandom);
    checkOutput("acc_busy", busy, 1'b1);
    checkOutput("acc_reqReady", reqReady, 1'b0);
    checkOutput("acc_rspValid", rspValid, 1'b0);
    checkOutput("acc_memWEn", memWEn, expWEn);
    checkOutput("acc_memAddr", memAddr, addr);
    if (we) checkOutput("acc_memWData", memWData, wdata);
    if (!expExc) checkOutput("acc_memSize", memSize, expSize);
    deviceWrite();
    @(posedge clk); #1;
    for (int h = 0; h <= holdCycles; h++) begin
      checkResponse("resp");
      if (h < holdCycles) begin
        @(posedge clk); #1;
      end
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    checkOutput("done_rspValid", rspValid, 1'b0);
    checkOutput("done_memWEn", memWEn, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rspValid"}, rspValid, 1'b0);
    checkOutput({tag, "_rspExc"}, rspExc, 1'b0);
    checkOutput({tag, "_rspCause"}, rspCause, 4'd0);
    checkOutput({tag, "_rspData"}, rspData, 32'd0);
    checkOutput({tag, "_rspRd"}, rspRd, 5'd0);
    checkOutput({tag, "_rspRdWe"}, rspRdWe, 1'b0);
    checkOutput({tag, "_memWEn"}, memWEn, 1'b0);
    checkOutput({tag, "_memSize"}, memSize, 3'b011);
    checkOutput({tag, "_memAddr"}, memAddr, 32'd0);
    checkOutput({tag, "_memWData"}, memWData, 32'd0);
    checkOutput({tag, "_reqReady"}, reqReady, 1'b1);
    checkOutput({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0]  b;
    logic        we;
    logic [31:0] addr;

    for (int i = 0; i < MEMB; i++) begin
      b         = 8'($urandom);
      devMem[i] = b;
      refMem[i] = b;
    end

    rstN      = 1'b0;
    reqValid  = 1'b0;
    reqWe     = 1'b0;
    reqFunct3 = 3'd0;
    reqAddr   = 32'd0;
    reqWData  = 32'd0;
    reqRd     = 5'd0;
    rspReady  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rstN = 1'b1;
    @(posedge clk); #1;

    // Store interrupted by reset during its access cycle must not write
    reqValid  = 1'b1;
    reqWe     = 1'b1;
    reqFunct3 = 3'b010;
    reqAddr   = 32'h40;
    reqWData  = 32'hDEADBEEF;
    reqRd     = 5'd3;
    @(posedge clk); #1;
    reqValid = 1'b0;
    checkOutput("midrst_acc_busy", busy, 1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_memWEn", memWEn, 1'b0);
    deviceWrite();
    @(posedge clk); #1;
    checkResetState("midrst");
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_release_reqReady", reqReady, 1'b1);
    applyStimulus(1'b0, 3'b010, 32'h40, 32'd0, 5'd4, 0);

    // Directed cases
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 5'd9, 0);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'd0, 5'd5, 0);
    checkOutput("lb_signext_value", rspData, 32'hFFFFFFA1);
    applyStimulus(1'b0, 3'b101, 32'h10, 32'd0, 5'd6, 0);
    checkOutput("lhu_value", rspData, 32'h0000C3D4);
    applyStimulus(1'b0, 3'b010, 32'h22, 32'd0, 5'd7, 0);
    applyStimulus(1'b1, 3'b001, 32'h31, 32'h12345678, 5'd8, 0);
    applyStimulus(1'b0, 3'b011, 32'h20, 32'd0, 5'd10, 0);
    applyStimulus(1'b1, 3'b111, 32'h24, 32'h55AA55AA, 5'd11, 0);
    applyStimulus(1'b0, 3'b110, 32'h21, 32'd0, 5'd12, 0);
    applyStimulus(1'b0, 3'b100, 32'h12, 32'd0, 5'd13, 5);
`ifdef LSU_BOUNDS_CHECK_EN
    applyStimulus(1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 5'd1, 0);
    applyStimulus(1'b1, 3'b010, 32'hFFE, 32'hCAFEF00D, 5'd1, 0);
    applyStimulus(1'b0, 3'b001, 32'hFFF, 32'd0, 5'd2, 0);
    applyStimulus(1'b1, 3'b000, 32'hFFF, 32'h000000EE, 5'd2, 0);
    applyStimulus(1'b0, 3'b100, 32'hFFF, 32'd0, 5'd2, 0);
`endif

    // Randomized traffic concentrated on a small window so loads hit stores
    for (int n = 0; n < 150; n++) begin
      we   = 1'($urandom);
      addr = ($urandom % 8 == 0) ? $urandom_range(4080, 4095) : $urandom_range(0, 63);
      applyStimulus(we, 3'($urandom), addr, $urandom, 5'($urandom), int'($urandom % 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
